// File: rtl/varray_bundler_if.sv
// Bus bundle for varray_bundler: upstream sparse-array read port plus
// downstream bundle handshake.
//   master : the bundler (drives va_re/va_read_addr and the out_* bundle)
//   slave  : the environment (upstream array and downstream consumer)
// Parameters: W element width, A address width; bundles are 4 lanes wide.
interface varray_bundler_if #(
    parameter int unsigned W = 18,
    parameter int unsigned A = 16
);
    // upstream sparse virtual array
    logic           va_re;
    logic [A-1:0]   va_read_addr;
    logic [W-1:0]   va_dat_r;
    logic [A-1:0]   va_len;
    logic           va_new_group;
    logic           drain;
    // downstream bundle
    logic           out_valid;
    logic           out_ready;
    logic [4*W-1:0] out_dat;
    logic [3:0]     out_mask;
    logic [A-1:0]   out_base_addr;
    logic           out_group_start;

    modport master (
        output va_re, va_read_addr,
        input  va_dat_r, va_len, va_new_group, drain,
        output out_valid, out_dat, out_mask, out_base_addr, out_group_start,
        input  out_ready
    );

    modport slave (
        input  va_re, va_read_addr,
        output va_dat_r, va_len, va_new_group, drain,
        input  out_valid, out_dat, out_mask, out_base_addr, out_group_start,
        output out_ready
    );
endinterface

// File: rtl/varray_bundler.sv
// varray_bundler: reads a sparse virtual array strictly in address order and
// packs elements into 4-lane bundles. A bundle closes when full, when the next
// element starts a new superscalar group, or on drain.
// Ports:
//   clk        clock, rising edge
//   reset      synchronous, active-high
//   va_bus     varray_bundler_if.master (upstream read port + bundle output)
//   rd_addr_o  current read address, status only
// va_re is combinational; all out_* fields are registered.
module varray_bundler #(
    parameter int unsigned VIRTUAL_ELEMENT_WIDTH = 18,
    parameter int unsigned VIRTUAL_ADDR_BITS     = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    varray_bundler_if.master             va_bus,
    output logic [VIRTUAL_ADDR_BITS-1:0] rd_addr_o
);
    localparam int unsigned W     = VIRTUAL_ELEMENT_WIDTH;
    localparam int unsigned A     = VIRTUAL_ADDR_BITS;
    localparam int unsigned LANES = 4;
    localparam int unsigned CW    = 3;

    logic [A-1:0]    rd_addr_q, rd_addr_d;
    logic [W-1:0]    lane_q [LANES];
    logic [W-1:0]    lane_d [LANES];
    logic [CW-1:0]   acc_count_q, acc_count_d;
    logic [A-1:0]    acc_base_q, acc_base_d;
    logic            acc_gs_q, acc_gs_d;
    logic            out_valid_q, out_valid_d;
    logic [4*W-1:0]  out_dat_q, out_dat_d;
    logic [3:0]      out_mask_q, out_mask_d;
    logic [A-1:0]    out_base_q, out_base_d;
    logic            out_gs_q, out_gs_d;

    logic            slot_free;
    logic            avail;
    logic            need_close;
    logic            rd_en;
    logic            transfer;
    logic [W-1:0]    lane_vis [LANES];

    // Read-side control: a pending closure may only proceed into a free slot.
    assign slot_free  = !out_valid_q || va_bus.out_ready;
    assign avail      = rd_addr_q < va_bus.va_len;
    assign need_close = (acc_count_q == CW'(LANES))
                     || (avail && va_bus.va_new_group && acc_count_q != '0);
    assign rd_en      = !reset && avail && (!need_close || slot_free);

    // Accumulator and output register next state.
    always_comb begin
        rd_addr_d   = rd_addr_q;
        lane_d      = lane_q;
        acc_count_d = acc_count_q;
        acc_base_d  = acc_base_q;
        acc_gs_d    = acc_gs_q;
        out_valid_d = out_valid_q;
        out_dat_d   = out_dat_q;
        out_mask_d  = out_mask_q;
        out_base_d  = out_base_q;
        out_gs_d    = out_gs_q;
        transfer    = 1'b0;

        for (int unsigned i = 0; i < LANES; i++) begin
            lane_vis[i] = (CW'(i) < acc_count_q) ? lane_q[i] : '0;
        end

        if (rd_en) begin
            rd_addr_d = rd_addr_q + A'(1);
            // rd_en with need_close implies slot_free: old bundle leaves
            // while the new element starts lane 0 in the same cycle.
            if (need_close || acc_count_q == '0) begin
                transfer    = need_close;
                lane_d[0]   = va_bus.va_dat_r;
                acc_count_d = CW'(1);
                acc_base_d  = rd_addr_q;
                acc_gs_d    = va_bus.va_new_group;
            end else begin
                lane_d[acc_count_q[1:0]] = va_bus.va_dat_r;
                acc_count_d              = acc_count_q + CW'(1);
            end
        end else if (acc_count_q != '0 && slot_free
                     && (acc_count_q == CW'(LANES) || va_bus.drain)) begin
            transfer    = 1'b1;
            acc_count_d = '0;
        end

        if (transfer) begin
            out_valid_d = 1'b1;
            out_dat_d   = {lane_vis[0], lane_vis[1], lane_vis[2], lane_vis[3]};
            out_mask_d  = {acc_count_q >= CW'(4), acc_count_q >= CW'(3),
                           acc_count_q >= CW'(2), acc_count_q >= CW'(1)};
            out_base_d  = acc_base_q;
            out_gs_d    = acc_gs_q;
        end else if (va_bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr_q   <= '0;
            for (int unsigned i = 0; i < LANES; i++) begin
                lane_q[i] <= '0;
            end
            acc_count_q <= '0;
            acc_base_q  <= '0;
            acc_gs_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_dat_q   <= '0;
            out_mask_q  <= '0;
            out_base_q  <= '0;
            out_gs_q    <= 1'b0;
        end else begin
            rd_addr_q   <= rd_addr_d;
            lane_q      <= lane_d;
            acc_count_q <= acc_count_d;
            acc_base_q  <= acc_base_d;
            acc_gs_q    <= acc_gs_d;
            out_valid_q <= out_valid_d;
            out_dat_q   <= out_dat_d;
            out_mask_q  <= out_mask_d;
            out_base_q  <= out_base_d;
            out_gs_q    <= out_gs_d;
        end
    end

    assign va_bus.va_re           = rd_en;
    assign va_bus.va_read_addr    = rd_addr_q;
    assign va_bus.out_valid       = out_valid_q;
    assign va_bus.out_dat         = out_dat_q;
    assign va_bus.out_mask        = out_mask_q;
    assign va_bus.out_base_addr   = out_base_q;
    assign va_bus.out_group_start = out_gs_q;
    assign rd_addr_o              = rd_addr_q;
endmodule

// File: tb/tb_varray_bundler.sv
// Testbench for varray_bundler: an array model of the upstream sparse array,
// a queue-based bundle model fed element by element, and a negedge monitor
// that scoreboards every accepted bundle and checks read/handshake rules.
module tb_varray_bundler;
    localparam int unsigned W    = 18;
    localparam int unsigned A    = 16;
    localparam int unsigned MEMD = 64;

    typedef struct {
        logic [A-1:0]   base;
        logic [3:0]     mask;
        logic           gs;
        logic [4*W-1:0] dat;
    } bundle_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [A-1:0] rd_addr_o;

    always #5 clk = ~clk;

    varray_bundler_if #(.W(W), .A(A)) bus ();

    varray_bundler #(
        .VIRTUAL_ELEMENT_WIDTH(W),
        .VIRTUAL_ADDR_BITS    (A)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .va_bus   (bus),
        .rd_addr_o(rd_addr_o)
    );

    // Upstream sparse array: unwritten slots read as 0 with the group flag set.
    logic [W-1:0] mem_dat [MEMD];
    logic         mem_gs  [MEMD];
    logic         mem_wr  [MEMD];
    logic [5:0]   rd_idx;

    always_comb begin
        rd_idx           = bus.va_read_addr[5:0];
        bus.va_dat_r     = '0;
        bus.va_new_group = 1'b1;
        if (bus.va_read_addr < A'(MEMD) && mem_wr[rd_idx]) begin
            bus.va_dat_r     = mem_dat[rd_idx];
            bus.va_new_group = mem_gs[rd_idx];
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [127:0] got,
                             input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bundle model: elements arrive in address order; a bundle is emitted
    // when a group starts, when 4 lanes are held, or on drain.
    bundle_t      exp_q[$];
    int           p_n;
    logic [A-1:0] p_base;
    logic         p_gs;
    logic [W-1:0] p_lane [4];

    task automatic model_emit();
        bundle_t      b;
        logic [W-1:0] v [4];
        for (int i = 0; i < 4; i++) v[i] = (i < p_n) ? p_lane[i] : '0;
        b.dat  = {v[0], v[1], v[2], v[3]};
        b.mask = 4'((1 << p_n) - 1);
        b.base = p_base;
        b.gs   = p_gs;
        exp_q.push_back(b);
        p_n = 0;
    endtask

    task automatic model_push(input logic [A-1:0] addr, input logic [W-1:0] d,
                              input logic g);
        if (p_n > 0 && g) model_emit();
        if (p_n == 0) begin
            p_base = addr;
            p_gs   = g;
        end
        p_lane[p_n] = d;
        p_n++;
        if (p_n == 4) model_emit();
    endtask

    // Stimulus drivers
    int ready_mode = 0;   // 0: low, 1: high, 2: random

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = 1'($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: read-address tracking, va_re rules, stability, scoreboard.
    int exp_rd;
    initial begin
        bundle_t b;
        bundle_t cur;
        bundle_t prev;
        logic    prev_stall;
        prev_stall = 1'b0;
        exp_rd     = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
                exp_rd     = 0;
            end else begin
                check_val("rd_addr", 128'(rd_addr_o), 128'(exp_rd));
                check_val("va_read_addr", 128'(bus.va_read_addr), 128'(exp_rd));
                if (exp_rd >= int'(bus.va_len))
                    check_val("va_re_no_data", 128'(bus.va_re), 128'(0));
                else if (bus.out_ready)
                    check_val("va_re_flow", 128'(bus.va_re), 128'(1));
                if (bus.va_re && exp_rd < int'(bus.va_len)) exp_rd++;

                cur.base = bus.out_base_addr;
                cur.mask = bus.out_mask;
                cur.gs   = bus.out_group_start;
                cur.dat  = bus.out_dat;
                if (prev_stall) begin
                    check_val("stall_valid", 128'(bus.out_valid), 128'(1));
                    check_val("stall_base", 128'(cur.base), 128'(prev.base));
                    check_val("stall_mask", 128'(cur.mask), 128'(prev.mask));
                    check_val("stall_gs", 128'(cur.gs), 128'(prev.gs));
                    check_val("stall_dat", 128'(cur.dat), 128'(prev.dat));
                end
                if (bus.out_valid)
                    check_val("mask_nonzero", 128'(bus.out_mask != 4'd0), 128'(1));
                if (bus.out_valid && bus.out_ready) begin
                    check_val("bundle_expected", 128'(exp_q.size() != 0), 128'(1));
                    if (exp_q.size() != 0) begin
                        b = exp_q.pop_front();
                        check_val("bundle_base", 128'(cur.base), 128'(b.base));
                        check_val("bundle_mask", 128'(cur.mask), 128'(b.mask));
                        check_val("bundle_gs", 128'(cur.gs), 128'(b.gs));
                        check_val("bundle_dat", 128'(cur.dat), 128'(b.dat));
                    end
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev       = cur;
            end
        end
    end

    task automatic write_elem(input int a, input logic [W-1:0] d, input logic g);
        logic [5:0] i;
        i          = 6'(a);
        mem_dat[i] = d;
        mem_gs[i]  = g;
        mem_wr[i]  = 1'b1;
    endtask

    task automatic extend_len(input int n);
        logic [5:0] i;
        for (int a = int'(bus.va_len); a < n; a++) begin
            i = 6'(a);
            if (mem_wr[i]) model_push(A'(a), mem_dat[i], mem_gs[i]);
            else           model_push(A'(a), '0, 1'b1);
        end
        bus.va_len = A'(n);
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        reset      = 1'b1;
        bus.drain  = 1'b0;
        bus.va_len = '0;
        for (int i = 0; i < int'(MEMD); i++) mem_wr[6'(i)] = 1'b0;
        exp_q.delete();
        p_n = 0;
        @(negedge clk);
        check_val("va_re_in_reset", 128'(bus.va_re), 128'(0));
        @(posedge clk);
        #1;
        check_val("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check_val("rst_out_mask", 128'(bus.out_mask), 128'(0));
        check_val("rst_out_dat", 128'(bus.out_dat), 128'(0));
        check_val("rst_out_base", 128'(bus.out_base_addr), 128'(0));
        check_val("rst_out_gs", 128'(bus.out_group_start), 128'(0));
        check_val("rst_rd_addr", 128'(rd_addr_o), 128'(0));
        reset = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!(exp_rd == int'(bus.va_len) && exp_q.size() == 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("wait_done_timeout", 128'(n < budget), 128'(1));
    endtask

    task automatic do_drain(input int budget);
        int n;
        n = 0;
        while (exp_rd != int'(bus.va_len) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("drain_read_timeout", 128'(n < budget), 128'(1));
        if (p_n > 0) model_emit();
        bus.drain = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("drain_timeout", 128'(n < budget), 128'(1));
        bus.drain = 1'b0;
    endtask

    initial begin
        int n_el;
        int len;
        reset      = 1'b1;
        bus.drain  = 1'b0;
        bus.va_len = '0;
        p_n        = 0;
        for (int i = 0; i < int'(MEMD); i++) mem_wr[6'(i)] = 1'b0;

        // Two groups [0..2] and [3..7]; element 7 held until drain.
        reset_dut();
        ready_mode = 1;
        for (int a = 0; a < 8; a++)
            write_elem(a, W'($urandom), 1'(a == 0 || a == 3));
        extend_len(8);
        wait_done(60);
        repeat (5) @(posedge clk);
        #1;
        check_val("hold_last_no_bundle", 128'(bus.out_valid), 128'(0));
        check_val("hold_last_rd_addr", 128'(rd_addr_o), 128'(8));
        do_drain(60);

        // Gaps at 2,3 read as zero-valued group starts.
        reset_dut();
        ready_mode = 1;
        write_elem(0, W'($urandom), 1'b1);
        write_elem(1, W'($urandom), 1'b0);
        write_elem(4, W'($urandom), 1'b1);
        write_elem(5, W'($urandom), 1'b0);
        extend_len(6);
        wait_done(60);
        do_drain(60);

        // Output blocked: two full bundles fill, then reads stall.
        reset_dut();
        ready_mode = 0;
        for (int a = 0; a < 9; a++)
            write_elem(a, W'($urandom), 1'(a == 0));
        extend_len(9);
        repeat (10) @(posedge clk);
        #1;
        check_val("stall_rd_addr", 128'(rd_addr_o), 128'(8));
        check_val("stall_va_re", 128'(bus.va_re), 128'(0));
        check_val("stall_out_valid", 128'(bus.out_valid), 128'(1));
        ready_mode = 1;
        wait_done(80);
        do_drain(60);

        // Partial bundle with no drain stays put.
        reset_dut();
        ready_mode = 1;
        write_elem(0, W'($urandom), 1'b1);
        write_elem(1, W'($urandom), 1'b0);
        extend_len(2);
        repeat (8) @(posedge clk);
        #1;
        check_val("partial_no_valid", 128'(bus.out_valid), 128'(0));
        check_val("partial_va_re", 128'(bus.va_re), 128'(0));
        check_val("partial_rd_addr", 128'(rd_addr_o), 128'(2));

        // Reach acc_count 3 with a stalled bundle, then reset mid-bundle.
        ready_mode = 0;
        for (int a = 2; a < 7; a++)
            write_elem(a, W'($urandom), 1'(a == 4));
        extend_len(7);
        repeat (10) @(posedge clk);
        #1;
        check_val("pre_reset_valid", 128'(bus.out_valid), 128'(1));
        check_val("pre_reset_rd_addr", 128'(rd_addr_o), 128'(7));
        reset_dut();
        ready_mode = 1;
        for (int a = 0; a < 3; a++)
            write_elem(a, W'($urandom), 1'(a == 0));
        extend_len(3);
        wait_done(60);
        do_drain(60);

        // Randomized rounds: gaps, random groups, growing va_len, random
        // backpressure and occasional mid-stream drains.
        for (int r = 0; r < 6; r++) begin
            reset_dut();
            ready_mode = 2;
            n_el = int'($urandom_range(20, 50));
            for (int a = 0; a < n_el; a++)
                if ($urandom_range(0, 7) != 0)
                    write_elem(a, W'($urandom), 1'($urandom_range(0, 2) == 0));
            len = 0;
            while (len < n_el) begin
                len = len + int'($urandom_range(1, 6));
                if (len > n_el) len = n_el;
                extend_len(len);
                repeat ($urandom_range(0, 6)) @(posedge clk);
                #1;
                if ($urandom_range(0, 4) == 0) do_drain(400);
            end
            do_drain(400);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
